// File: rtl/wavegen_pkg.sv
// Shared types and the phase-to-sample mapping for the waveform generator.
package wavegen_pkg;

    typedef enum logic [1:0] {
        MODE_SAW     = 2'd0,
        MODE_TRI     = 2'd1,
        MODE_SQR     = 2'd2,
        MODE_ONESHOT = 2'd3
    } wave_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } wave_state_e;

    // Working width of the mapping function; callers zero-extend their
    // DATA_W slices into it and truncate the result back to DATA_W.
    localparam int unsigned MAP_W = 32;

    // p: top DATA_W phase bits, t: the DATA_W bits just below the MSB,
    // msb: phase MSB. Upper bits of the result beyond DATA_W are don't-care.
    function automatic logic [MAP_W-1:0] wave_map(
        input wave_mode_e       mode,
        input logic             invert,
        input logic             msb,
        input logic [MAP_W-1:0] p,
        input logic [MAP_W-1:0] t
    );
        logic [MAP_W-1:0] r;
        case (mode)
            MODE_TRI: r = msb ? ~t : t;
            MODE_SQR: r = msb ? '1 : '0;
            default:  r = p;
        endcase
        if (invert) begin
            r = ~r;
        end
        return r;
    endfunction

endpackage

// File: rtl/wavegen_if.sv
// Control and sample bus of the waveform generator.
interface wavegen_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned DIV_W  = 30
) ();

    logic              enable;
    logic              phase_clr;
    logic [1:0]        mode;
    logic              slope_sign;
    logic [ACC_W-1:0]  step;
    logic [DIV_W-1:0]  tick_period;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              wrap;

    modport master (
        output enable, phase_clr, mode, slope_sign, step, tick_period,
        input  sample, sample_valid, wrap
    );

    modport slave (
        input  enable, phase_clr, mode, slope_sign, step, tick_period,
        output sample, sample_valid, wrap
    );

endinterface

// File: rtl/wavegen_tick_divider.sv
// Sample-rate divider: one tick every max(period,1) enabled cycles.
module wavegen_tick_divider #(
    parameter int unsigned DIV_W = 30
) (
    input  logic             qzt_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;
    logic             terminal;

    // Terminal count; periods 0 and 1 both tick every cycle. Using >= lets a
    // shortened period take effect at the next comparison without overrun.
    always_comb begin
        last     = (period > DIV_W'(1)) ? period - DIV_W'(1) : '0;
        terminal = (cnt >= last);
        tick     = enable && !clear && terminal;
    end

    // Count register: cleared by reset/clear, frozen while disabled.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= terminal ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/wavegen_core.sv
// Phase-accumulator waveform generator: saw / triangle / square / one-shot.
module wavegen_core
    import wavegen_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned DIV_W  = 30
) (
    input  logic      qzt_clk,
    input  logic      reset,
    wavegen_if.slave  bus
);

    wave_state_e       state;
    wave_state_e       state_nxt;
    wave_mode_e        mode_in;
    logic [ACC_W-1:0]  phase;
    logic [ACC_W-1:0]  phase_nxt;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  out_ph;
    logic              carry;
    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] sample_nxt;
    logic              valid_q;
    logic              valid_nxt;
    logic              wrap_q;
    logic              wrap_nxt;
    logic              tick;

    wavegen_tick_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .enable  (bus.enable),
        .clear   (bus.phase_clr),
        .period  (bus.tick_period),
        .tick    (tick)
    );

    // Next state, next phase and the sample for the phase being written.
    // A tick taken in IDLE (enable just rose) advances like RUN so no tick
    // is lost waiting for the state register to catch up.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        out_ph     = phase;
        sample_nxt = sample_q;
        valid_nxt  = 1'b0;
        wrap_nxt   = 1'b0;
        mode_in    = wave_mode_e'(bus.mode);
        {carry, sum} = {1'b0, phase} + {1'b0, bus.step};

        if (bus.phase_clr) begin
            phase_nxt = '0;
            out_ph    = '0;
            valid_nxt = 1'b1;
            state_nxt = bus.enable ? ST_RUN : ST_IDLE;
        end else if (tick) begin
            valid_nxt = 1'b1;
            if (state == ST_HOLD) begin
                if (mode_in != MODE_ONESHOT) begin
                    state_nxt = ST_RUN;
                end
            end else if (mode_in == MODE_ONESHOT && carry) begin
                phase_nxt = '1;
                out_ph    = '1;
                wrap_nxt  = 1'b1;
                state_nxt = ST_HOLD;
            end else begin
                phase_nxt = sum;
                out_ph    = sum;
                wrap_nxt  = carry;
                state_nxt = ST_RUN;
            end
        end else if (!bus.enable) begin
            if (state == ST_RUN) begin
                state_nxt = ST_IDLE;
            end
        end else if (state == ST_IDLE) begin
            state_nxt = ST_RUN;
        end

        if (valid_nxt) begin
            sample_nxt = DATA_W'(wave_map(mode_in, bus.slope_sign, out_ph[ACC_W-1],
                                          MAP_W'(out_ph[ACC_W-1 -: DATA_W]),
                                          MAP_W'(out_ph[ACC_W-2 -: DATA_W])));
        end
    end

    // FSM state register.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase accumulator and registered outputs.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            phase    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            sample_q <= sample_nxt;
            valid_q  <= valid_nxt;
            wrap_q   <= wrap_nxt;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.wrap         = wrap_q;

endmodule

// File: tb/tb_wavegen_core.sv
// Self-checking bench for wavegen_core: directed scenarios plus random traffic
// compared cycle by cycle against an arithmetic model of the waveform rules.
module tb_wavegen_core;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 16;
    localparam int unsigned VW = 30;
    localparam int unsigned TOP = (1 << DW) - 1;
    localparam longint unsigned PH_MOD = 64'd1 << AW;

    logic qzt_clk = 1'b0;
    logic reset   = 1'b1;

    always #5 qzt_clk = ~qzt_clk;

    wavegen_if #(.DATA_W(DW), .ACC_W(AW), .DIV_W(VW)) bus ();

    wavegen_core #(.DATA_W(DW), .ACC_W(AW), .DIV_W(VW)) dut (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Waveform value of a phase, from the arithmetic definition of each shape.
    function automatic int unsigned ref_map(input int unsigned md, input bit sgn, input int unsigned ph);
        int unsigned half;
        int unsigned p;
        int unsigned t;
        int unsigned r;
        bit          m;
        half = 1 << (AW - 1);
        p    = ph / (1 << (AW - DW));
        t    = (ph % half) / (1 << (AW - 1 - DW));
        m    = (ph >= half);
        case (md)
            1:       r = m ? TOP - t : t;
            2:       r = m ? TOP : 0;
            default: r = p;
        endcase
        if (sgn) r = TOP - r;
        return r;
    endfunction

    // Model state
    int unsigned     m_phase  = 0;
    int unsigned     m_cnt    = 0;
    bit              m_done   = 1'b0;
    int unsigned     m_sample = 0;
    bit              m_valid  = 1'b0;
    bit              m_wrap   = 1'b0;
    int unsigned     m_per;
    longint unsigned m_tot;

    // Model: one step per clock edge, from the inputs present at that edge.
    always @(posedge qzt_clk) begin
        if (reset) begin
            m_phase = 0; m_cnt = 0; m_done = 0;
            m_sample = 0; m_valid = 0; m_wrap = 0;
        end else begin
            m_valid = 0;
            m_wrap  = 0;
            if (bus.phase_clr) begin
                m_phase  = 0;
                m_cnt    = 0;
                m_done   = 0;
                m_valid  = 1;
                m_sample = ref_map(bus.mode, bus.slope_sign, 0);
            end else if (bus.enable) begin
                m_per = (bus.tick_period == 0) ? 1 : int'(bus.tick_period);
                if (m_cnt + 1 >= m_per) begin
                    m_cnt   = 0;
                    m_valid = 1;
                    if (m_done) begin
                        if (bus.mode != 2'd3) m_done = 0;
                    end else begin
                        m_tot = longint'(m_phase) + longint'(bus.step);
                        if (m_tot >= PH_MOD) begin
                            m_wrap = 1;
                            if (bus.mode == 2'd3) begin
                                m_phase = int'(PH_MOD - 1);
                                m_done  = 1;
                            end else begin
                                m_phase = int'(m_tot - PH_MOD);
                            end
                        end else begin
                            m_phase = int'(m_tot);
                        end
                    end
                    m_sample = ref_map(bus.mode, bus.slope_sign, m_phase);
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge qzt_clk) begin
        if (chk_en) begin
            check("sample", bus.sample, m_sample);
            check("sample_valid", bus.sample_valid, m_valid);
            check("wrap", bus.wrap, m_wrap);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge qzt_clk);
    endtask

    int vcnt;
    int ones;
    int wcnt;

    initial begin
        bus.enable = 0; bus.phase_clr = 0; bus.mode = 2'd0; bus.slope_sign = 0;
        bus.step = '0; bus.tick_period = '0;

        // Pin the model's mapping with hand-computed values
        check("pin_saw", ref_map(0, 0, 32'h0010), 1);
        check("pin_saw_inv", ref_map(0, 1, 32'h0010), 4094);
        check("pin_tri_up", ref_map(1, 0, 32'h0010), 2);
        check("pin_tri_top", ref_map(1, 0, 32'h8000), 4095);
        check("pin_sqr_hi", ref_map(2, 0, 32'h8000), 4095);
        check("pin_sqr_lo", ref_map(2, 0, 32'h7F00), 0);

        cyc(3);
        chk_en = 1;
        check("rst_sample", bus.sample, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_wrap", bus.wrap, 0);

        // 1. rising saw
        reset = 0; bus.mode = 2'd0; bus.step = 16'd16; bus.tick_period = 30'd1; bus.enable = 1;
        cyc(1);
        check("saw_first", bus.sample, 1);
        check("saw_first_valid", bus.sample_valid, 1);
        cyc(4095);
        check("saw_wrap_sample", bus.sample, 0);
        check("saw_wrap", bus.wrap, 1);
        cyc(1);
        check("saw_after_wrap", bus.sample, 1);

        // 2. falling saw
        bus.phase_clr = 1; bus.slope_sign = 1;
        cyc(1);
        bus.phase_clr = 0;
        check("fall_clr", bus.sample, 4095);
        cyc(1);
        check("fall_first", bus.sample, 4094);
        cyc(4100);

        // 3. triangle
        bus.phase_clr = 1; bus.mode = 2'd1; bus.slope_sign = 0;
        cyc(1);
        bus.phase_clr = 0;
        check("tri_clr", bus.sample, 0);
        cyc(1);
        check("tri_first", bus.sample, 2);
        cyc(2047);
        check("tri_peak", bus.sample, 4095);
        cyc(1);
        check("tri_down", bus.sample, 4093);
        cyc(2100);

        // 4. square through the divider
        bus.phase_clr = 1; bus.mode = 2'd2; bus.step = 16'h0100; bus.tick_period = 30'd5;
        cyc(1);
        bus.phase_clr = 0;
        check("sqr_clr", bus.sample, 0);
        vcnt = 0; ones = 0;
        for (int i = 0; i < 1400; i++) begin
            cyc(1);
            if (bus.sample_valid) begin
                vcnt++;
                if (bus.sample == 12'hFFF) ones++;
            end
        end
        check("sqr_valid_count", vcnt, 280);
        check("sqr_high_count", ones, 128);

        // 5. one-shot ramp
        bus.tick_period = 30'd1; bus.mode = 2'd3; bus.step = 16'h4000; bus.phase_clr = 1;
        cyc(1);
        bus.phase_clr = 0;
        check("os_clr", bus.sample, 0);
        cyc(1); check("os_1", bus.sample, 12'h400);
        cyc(1); check("os_2", bus.sample, 12'h800);
        cyc(1); check("os_3", bus.sample, 12'hC00);
        cyc(1); check("os_end", bus.sample, 12'hFFF);
        check("os_end_wrap", bus.wrap, 1);
        vcnt = 0; ones = 0; wcnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.sample_valid) vcnt++;
            if (bus.sample == 12'hFFF) ones++;
            if (bus.wrap) wcnt++;
        end
        check("os_hold_valid", vcnt, 10);
        check("os_hold_level", ones, 10);
        check("os_hold_wrap", wcnt, 0);
        bus.phase_clr = 1;
        cyc(1);
        bus.phase_clr = 0;
        check("os_restart_clr", bus.sample, 0);
        cyc(1);
        check("os_restart", bus.sample, 12'h400);

        // 6a. clear on a tick that would carry
        bus.mode = 2'd0; bus.step = 16'd16; bus.phase_clr = 1;
        cyc(1);
        bus.phase_clr = 0;
        cyc(4095);
        check("pri_pre", bus.sample, 4095);
        bus.phase_clr = 1;
        cyc(1);
        bus.phase_clr = 0;
        check("pri_sample", bus.sample, 0);
        check("pri_wrap", bus.wrap, 0);
        check("pri_valid", bus.sample_valid, 1);

        // 6b. freeze
        bus.enable = 0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bus.sample_valid) vcnt++;
        end
        check("freeze_valid", vcnt, 0);
        bus.enable = 1;

        // 6c. reset mid-ramp
        bus.mode = 2'd3; bus.step = 16'h1000; bus.phase_clr = 1;
        cyc(1);
        bus.phase_clr = 0;
        cyc(5);
        check("rr_pre", bus.sample, 12'h500);
        reset = 1;
        cyc(1);
        check("rr_sample", bus.sample, 0);
        check("rr_valid", bus.sample_valid, 0);
        check("rr_wrap", bus.wrap, 0);
        reset = 0;
        cyc(1);
        check("rr_restart", bus.sample, 12'h100);

        // 7. random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.phase_clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 5) bus.enable = ~bus.enable;
            if ($urandom_range(0, 99) < 3) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2) bus.slope_sign = ~bus.slope_sign;
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 3))
                    0:       bus.step = '0;
                    1:       bus.step = AW'($urandom_range(0, 16'h03FF));
                    2:       bus.step = 16'h4000;
                    default: bus.step = AW'($urandom);
                endcase
            end
            if ($urandom_range(0, 99) < 2) bus.tick_period = VW'($urandom_range(0, 6));
            reset = ($urandom_range(0, 999) < 3);
            cyc(1);
        end
        reset = 0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
